// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared defaults and flush FSM encoding for the store buffer.
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 8;
  localparam int SB_DW = 8;
  localparam logic ST_RUN = 1'b0;
  localparam logic ST_FLUSH = 1'b1;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest valid buffered entry whose address matches the load address.
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic [DEPTH-1:0][AW-1:0]     ent_addr,
  input  logic [DEPTH-1:0][DW-1:0]     ent_data,
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     oldest,
  input  logic [AW-1:0]                cpu_addr,
  output logic                         hit,
  output logic [DW-1:0]                fwd_data
);
  localparam int PW = $clog2(DEPTH);
  // walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[PW'(oldest + PW'(i))] && ent_addr[PW'(oldest + PW'(i))] == cpu_addr) begin
        hit = 1'b1;
        fwd_data = ent_data[PW'(oldest + PW'(i))];
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of pending stores drained to SRAM, with load forwarding and sync flush.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic          sync,
  output logic [DW-1:0] cpu_rdata,
  output logic          breq,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic state_q, state_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [DEPTH-1:0] valid;
  logic flushing, push, pop, hit;
  logic [DW-1:0] fwd_data;
  // a sync request stalls the processor in the very cycle it arrives, so nothing slips in ahead of the drain
  always_comb begin
    flushing = state_q == ST_FLUSH || (sync && count_q != '0);
    breq = (cpu_we && count_q == CW'(DEPTH)) || (flushing && (cpu_we || cpu_re));
    push = cpu_we && !breq;
    pop = rst && count_q != '0 && (!cpu_re || flushing);
    mem_we = pop;
    mem_addr = pop ? addr_q[head_q] : cpu_addr;
    mem_wdata = data_q[head_q];
    cpu_rdata = hit ? fwd_data : mem_rdata;
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    state_d = flushing && count_d != '0 ? ST_FLUSH : ST_RUN;
    addr_d = addr_q;
    data_d = data_q;
    if (push) begin
      addr_d[tail_q] = cpu_addr;
      data_d[tail_q] = cpu_wdata;
    end
    for (int j = 0; j < DEPTH; j++) valid[j] = CW'(PW'(PW'(j) - head_q)) < count_q;
  end
  sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
    .ent_addr(addr_q),
    .ent_data(data_q),
    .valid(valid),
    .oldest(head_q),
    .cpu_addr(cpu_addr),
    .hit(hit),
    .fwd_data(fwd_data)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      state_q <= ST_RUN;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of store draining, forwarding, sync flush and reset.
module tb_store_buffer;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_we = 1'b0, cpu_re = 1'b0, sync = 1'b0, breq, mem_we;
  logic [7:0] mem [256];
  logic [15:0] wlog [$];
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  store_buffer dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_re(cpu_re), .sync(sync), .cpu_rdata(cpu_rdata), .breq(breq), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic we, input logic re, input logic sy, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_we = we;
    cpu_re = re;
    sync = sy;
    cpu_addr = a;
    cpu_wdata = d;
    #1;
  endtask
  task automatic check_log(input string tag, input int idx, input logic [15:0] exp);
    check(tag, idx < wlog.size() ? {16'h0, wlog[idx]} : 32'hFFFF_FFFF, {16'h0, exp});
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 8'h44, 8'h00);
    check("rst_mem_we", mem_we, 0);
    check("rst_breq", breq, 0);
    check("rst_mem_addr", mem_addr, 8'h44);
    check("rst_rdata", cpu_rdata, 8'hE1);
    // single store drains the following cycle
    wlog.delete();
    drive(1, 0, 0, 8'h10, 8'h2A);
    check("st_breq", breq, 0);
    check("st_no_early_we", mem_we, 0);
    drive(0, 0, 0, 8'h00, 8'h00);
    check("st_drain_we", mem_we, 1);
    check("st_drain_addr", mem_addr, 8'h10);
    check("st_drain_data", mem_wdata, 8'h2A);
    drive(0, 0, 0, 8'h00, 8'h00);
    check("st_empty_we", mem_we, 0);
    check("st_sram", mem[8'h10], 8'h2A);
    // five stores under continuous loads, fifth stalls
    wlog.delete();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 0, 8'(8'h50 + i), 8'(i));
      check($sformatf("b2b_breq%0d", i), breq, i == 5);
      check($sformatf("b2b_we%0d", i), mem_we, 0);
    end
    drive(1, 0, 0, 8'h55, 8'h05);
    check("b2b_full_breq", breq, 1);
    check("b2b_full_drain", mem_addr, 8'h51);
    drive(1, 0, 0, 8'h55, 8'h05);
    check("b2b_accept", breq, 0);
    repeat (4) drive(0, 0, 0, 8'h00, 8'h00);
    check("b2b_idle_we", mem_we, 0);
    for (int i = 0; i < 5; i++) check_log($sformatf("b2b_order%0d", i), i, {8'(8'h51 + i), 8'(i + 1)});
    // forwarding picks the youngest duplicate
    wlog.delete();
    drive(1, 1, 0, 8'h20, 8'h11);
    drive(1, 1, 0, 8'h20, 8'h22);
    drive(0, 1, 0, 8'h20, 8'h00);
    check("fwd_young", cpu_rdata, 8'h22);
    check("fwd_no_drain", mem_we, 0);
    check("fwd_load_addr", mem_addr, 8'h20);
    drive(0, 1, 0, 8'h21, 8'h00);
    check("fwd_miss", cpu_rdata, 8'h84);
    repeat (2) drive(0, 0, 0, 8'h00, 8'h00);
    drive(0, 1, 0, 8'h20, 8'h00);
    check("fwd_sram_after", cpu_rdata, 8'h22);
    check_log("dup_order0", 0, 16'h2011);
    check_log("dup_order1", 1, 16'h2022);
    // sync flush with a pending store request
    wlog.delete();
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 8'(8'h60 + i), 8'(8'hA0 + i));
    drive(1, 0, 1, 8'h63, 8'hA3);
    check("sync_breq0", breq, 1);
    check("sync_addr0", mem_addr, 8'h60);
    drive(1, 0, 0, 8'h63, 8'hA3);
    check("sync_breq1", breq, 1);
    check("sync_addr1", mem_addr, 8'h61);
    drive(1, 0, 0, 8'h63, 8'hA3);
    check("sync_breq2", breq, 1);
    check("sync_addr2", mem_addr, 8'h62);
    drive(1, 0, 0, 8'h63, 8'hA3);
    check("sync_accept", breq, 0);
    check("sync_run_we", mem_we, 0);
    drive(0, 0, 0, 8'h00, 8'h00);
    check("sync_new_addr", mem_addr, 8'h63);
    check("sync_new_data", mem_wdata, 8'hA3);
    drive(0, 0, 0, 8'h00, 8'h00);
    check("sync_writes", wlog.size(), 4);
    // reset discards buffered stores
    wlog.delete();
    drive(1, 1, 0, 8'h30, 8'h77);
    drive(1, 1, 0, 8'h31, 8'h78);
    @(negedge clk);
    rst = 1'b0;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    cpu_addr = 8'h30;
    #1;
    check("mrst_we_in", mem_we, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_we_after", mem_we, 0);
    drive(0, 0, 0, 8'h31, 8'h00);
    check("mrst_we_later", mem_we, 0);
    drive(0, 1, 0, 8'h30, 8'h00);
    check("mrst_load", cpu_rdata, 8'h95);
    check("mrst_no_writes", wlog.size(), 0);
    // full buffer stall, drain, then accept to refill to DEPTH
    wlog.delete();
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 8'(8'h70 + i), 8'(8'hB0 + i));
    drive(1, 0, 0, 8'h74, 8'hB4);
    check("full_breq", breq, 1);
    check("full_drain", mem_we, 1);
    drive(1, 1, 0, 8'h74, 8'hB4);
    check("full_accept", breq, 0);
    drive(1, 1, 0, 8'h75, 8'hB5);
    check("full_again", breq, 1);
    repeat (5) drive(0, 0, 0, 8'h00, 8'h00);
    check("full_idle_we", mem_we, 0);
    for (int i = 0; i < 5; i++) check_log($sformatf("full_order%0d", i), i, {8'(8'h70 + i), 8'(8'hB0 + i)});
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered stores; power of two, 2..16.
REQ-002 Parameter AW, default 8: address width.
REQ-003 Parameter DW, default 8: data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 cpu_addr  input  AW  processor load/store address.
REQ-007 cpu_wdata  input  DW  processor store data.
REQ-008 cpu_we  input  1  processor store request.
REQ-009 cpu_re  input  1  processor load request.
REQ-010 sync  input  1  drain request; buffer empties before further stores are taken.
REQ-011 cpu_rdata  output  DW  load data returned to processor, same cycle.
REQ-012 breq  output  1  stall to processor; store or load not accepted this cycle.
REQ-013 mem_addr  output  AW  SRAM read/write address.
REQ-014 mem_wdata  output  DW  SRAM write data.
REQ-015 mem_we  output  1  SRAM write enable; SRAM captures on the rising edge.
REQ-016 mem_rdata  input  DW  SRAM combinational read data.

Function
REQ-017 The block SHALL hold up to DEPTH {addr,data} entries in FIFO order, tracked by head, tail and count (0..DEPTH); pointers wrap modulo DEPTH.
REQ-018 The block SHALL accept a store (push at tail) on a rising edge when cpu_we=1 and breq=0.
REQ-019 breq SHALL be 1 when cpu_we=1 and count==DEPTH, or when state is FLUSH and (cpu_we or cpu_re)=1; otherwise 0.
REQ-020 A full buffer SHALL NOT accept a store even if a drain occurs that same cycle; the store is accepted next cycle.
REQ-021 Drain: when count>0 and cpu_re=0, mem_we=1, mem_addr/mem_wdata = head entry, and head pops on the edge.
REQ-022 When cpu_re=1 and not stalled, mem_we=0, mem_addr=cpu_addr, and no drain occurs; loads have port priority.
REQ-023 When idle (count==0, cpu_re=0), mem_we=0 and mem_addr=cpu_addr.
REQ-024 Load forwarding: cpu_rdata SHALL equal data of the youngest valid entry whose addr==cpu_addr, else mem_rdata; zero-cycle latency.
REQ-025 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-026 A store to an address already buffered SHALL push a new entry; duplicates are not coalesced, and SRAM writes occur in program order.
REQ-027 Store latency: a store accepted on edge N SHALL reach SRAM no earlier than edge N+1 (mem_we high in cycle N+1 if the port is free and it is at head).
REQ-028 FSM states RUN and FLUSH; RUN->FLUSH on sync=1 with count>0; FLUSH->RUN when count==0 after the edge; sync=1 with count==0 stays in RUN.
REQ-029 In FLUSH, draining SHALL proceed every cycle (processor requests are stalled, so cpu_re does not block the drain).

Reset
REQ-030 On rising edge with rst=0: count=0, head=0, tail=0, state=RUN; entry storage need not be cleared.
REQ-031 After reset, outputs SHALL be mem_we=0, breq=0, mem_addr=cpu_addr, cpu_rdata=mem_rdata.
REQ-032 Reset mid-operation SHALL discard all buffered stores; none are written to SRAM afterwards.

Structure
REQ-033 AW, DW, DEPTH defaults and the RUN/FLUSH state encoding SHALL live in a shared package/header store_buffer_pkg.
REQ-034 The youngest-match forwarding lookup SHALL be one sub-module, sb_fwd_match (inputs: entry arrays, valid mask, age order, cpu_addr; outputs: hit, data).

Verification
REQ-035 Reset, store addr 0x10 data 0x2A with cpu_re=0 -> mem_we=1, mem_addr=0x10, mem_wdata=0x2A next cycle; count returns to 0.
REQ-036 Five back-to-back stores (0x01..0x05) under continuous cpu_re=1 -> breq=1 on the fifth; after cpu_re drops, SRAM writes occur in order 0x01..0x05.
REQ-037 Stores 0x20<-0x11 then 0x20<-0x22 buffered, load 0x20 -> cpu_rdata=0x22; load 0x21 -> cpu_rdata=mem_rdata.
REQ-038 Three stores buffered, sync=1 with cpu_we=1 -> breq=1 for three cycles, three SRAM writes, then state RUN and the store is accepted.
REQ-039 Two stores buffered, rst=0 for one cycle -> mem_we stays 0 thereafter, load of a stored address returns mem_rdata.
REQ-040 Full buffer with cpu_re=0 and cpu_we=1 -> breq=1 that cycle, one drain, store accepted on the following edge, count==DEPTH.
